call_scheduler: RTL



---
 rtl/elevator_pkg.sv | 21 ++
 rtl/next_floor_picker.sv | 79 +++++++
 rtl/call_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator control slice.
//   FLOOR_W / N_FLOORS : default floor encoding width and floor count
//   state_t            : call scheduler states (IDLE, MOVE, DWELL)
//   dir_t              : SCAN travel direction (UP, DOWN)
package elevator_pkg;

    localparam int FLOOR_W  = 2;
    localparam int N_FLOORS = 2 ** FLOOR_W;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DWELL
    } state_t;

    typedef enum logic {
        UP,
        DOWN
    } dir_t;

endpackage

// File: rtl/next_floor_picker.sv
// Combinational SCAN target selection.
// Finds the nearest pending floor strictly beyond the current floor in the
// current direction; if there is none, it reverses and looks the other way.
// The current floor itself is never a pick.
//   pending    in  : outstanding-request set, bit i = floor i
//   floor      in  : current floor
//   dir        in  : current travel direction
//   pick_valid out : a pick exists
//   pick_floor out : chosen floor (0 when no pick)
//   pick_dir   out : direction toward pick_floor (dir when no pick)
module next_floor_picker
    import elevator_pkg::*;
#(
    parameter int FLOOR_W = elevator_pkg::FLOOR_W
) (
    input  logic [2**FLOOR_W-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    input  dir_t                  dir,
    output logic                  pick_valid,
    output logic [FLOOR_W-1:0]    pick_floor,
    output dir_t                  pick_dir
);

    localparam int N_FLOORS = 2 ** FLOOR_W;

    logic                up_valid;
    logic [FLOOR_W-1:0]  up_floor;
    logic                dn_valid;
    logic [FLOOR_W-1:0]  dn_floor;

    // Scan above from the top down so the last hit is the nearest one; scan
    // below from the bottom up for the same reason.
    always_comb begin
        up_valid = 1'b0;
        up_floor = '0;
        dn_valid = 1'b0;
        dn_floor = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > floor)) begin
                up_valid = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < floor)) begin
                dn_valid = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_floor = '0;
        pick_dir   = dir;
        if (dir == UP) begin
            if (up_valid) begin
                pick_valid = 1'b1;
                pick_floor = up_floor;
                pick_dir   = UP;
            end else if (dn_valid) begin
                pick_valid = 1'b1;
                pick_floor = dn_floor;
                pick_dir   = DOWN;
            end
        end else begin
            if (dn_valid) begin
                pick_valid = 1'b1;
                pick_floor = dn_floor;
                pick_dir   = DOWN;
            end else if (up_valid) begin
                pick_valid = 1'b1;
                pick_floor = up_floor;
                pick_dir   = UP;
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// Elevator call scheduler: latches call buttons into a pending set, picks the
// next target with a direction-preserving SCAN policy, and times the door
// dwell at each served floor. All outputs are registered.
//   clk       in  : rising-edge clock
//   rst       in  : asynchronous active-low reset
//   call_req  in  : per-floor call buttons
//   floor     in  : current floor from the elevator FSM
//   target    out : target floor to the elevator FSM
//   stop      out : hold the car
//   door_open out : dwelling at a served floor
//   pending   out : outstanding-request set
//   busy      out : scheduler not IDLE
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**FLOOR_W-1:0] call_req,
    input  logic [FLOOR_W-1:0]    floor,
    output logic [FLOOR_W-1:0]    target,
    output logic                  stop,
    output logic                  door_open,
    output logic [2**FLOOR_W-1:0] pending,
    output logic                  busy
);

    localparam int N_FLOORS = 2 ** FLOOR_W;
    localparam int CNT_W    = $clog2(DWELL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t               state;
    state_t               state_next;
    dir_t                 dir;
    dir_t                 dir_next;
    logic [FLOOR_W-1:0]   target_next;
    logic [N_FLOORS-1:0]  pending_next;
    logic [N_FLOORS-1:0]  clear_mask;
    logic [CNT_W-1:0]     dwell_cnt;
    logic [CNT_W-1:0]     dwell_next;

    logic                 pick_valid;
    logic [FLOOR_W-1:0]   pick_floor;
    dir_t                 pick_dir;
    logic                 intercept;

    next_floor_picker #(
        .FLOOR_W (FLOOR_W)
    ) u_picker (
        .pending    (pending),
        .floor      (floor),
        .dir        (dir),
        .pick_valid (pick_valid),
        .pick_floor (pick_floor),
        .pick_dir   (pick_dir)
    );

    // While moving, the picker's nearest-ahead floor in the travel direction
    // is an intercept only if it lies short of the current target.
    always_comb begin
        intercept = 1'b0;
        if (pick_valid && (pick_dir == dir)) begin
            if (dir == UP) begin
                intercept = (pick_floor < target);
            end else begin
                intercept = (pick_floor > target);
            end
        end
    end

    always_comb begin
        state_next  = state;
        dir_next    = dir;
        target_next = target;
        dwell_next  = dwell_cnt;
        clear_mask  = '0;
        case (state)
            IDLE: begin
                if (pending[floor]) begin
                    state_next        = DWELL;
                    clear_mask[floor] = 1'b1;
                    dwell_next        = DWELL_LOAD;
                end else if (pick_valid) begin
                    state_next  = MOVE;
                    target_next = pick_floor;
                    dir_next    = pick_dir;
                end
            end
            MOVE: begin
                if (floor == target) begin
                    state_next         = DWELL;
                    clear_mask[target] = 1'b1;
                    dwell_next         = DWELL_LOAD;
                end else if (intercept) begin
                    target_next = pick_floor;
                end
            end
            DWELL: begin
                // A press for the floor being served keeps the door open
                // instead of queueing a second visit.
                clear_mask[floor] = 1'b1;
                if (call_req[floor]) begin
                    dwell_next = DWELL_LOAD;
                end else if (dwell_cnt != '0) begin
                    dwell_next = dwell_cnt - CNT_W'(1);
                end else if (pick_valid) begin
                    state_next  = MOVE;
                    target_next = pick_floor;
                    dir_next    = pick_dir;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pending_next = (pending | call_req) & ~clear_mask;

    // Outputs are derived from the next state so they line up with the
    // state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dir       <= UP;
            pending   <= '0;
            target    <= '0;
            dwell_cnt <= '0;
            stop      <= 1'b1;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            dir       <= dir_next;
            pending   <= pending_next;
            target    <= target_next;
            dwell_cnt <= dwell_next;
            stop      <= (state_next != MOVE);
            door_open <= (state_next == DWELL);
            busy      <= (state_next != IDLE);
        end
    end

endmodule
